// File: rtl/flag_branch_unit.sv
// Condition-code register with a conditional-jump resolver and one-cycle flush.
// Also keeps a single-entry CCR shadow for interrupt entry and RTI.
module flag_branch_unit #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flag_we,
  input  logic         in_carry,
  input  logic         in_zero,
  input  logic         in_neg,
  input  logic         set_carry,
  input  logic         clr_carry,
  input  logic         br_valid,
  input  logic [1:0]   br_cond,
  input  logic [N-1:0] br_target,
  input  logic         int_save,
  input  logic         rti_restore,
  output logic [2:0]   ccr,
  output logic         taken,
  output logic         flush,
  output logic [N-1:0] redirect_pc
);

  localparam logic IDLE  = 1'b0;
  localparam logic FLUSH = 1'b1;

  localparam logic [1:0] COND_JZ  = 2'd0;
  localparam logic [1:0] COND_JN  = 2'd1;
  localparam logic [1:0] COND_JC  = 2'd2;
  localparam logic [1:0] COND_JMP = 2'd3;

  logic       state;
  logic [2:0] shadow;
  logic       shadow_valid;

  logic       cond_true;
  logic       br_take;
  logic       do_restore;
  logic [2:0] ccr_next;

  // Conditions look only at the registered ccr, never at this cycle's ALU flags.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      COND_JZ:  cond_true = ccr[0];
      COND_JN:  cond_true = ccr[1];
      COND_JC:  cond_true = ccr[2];
      COND_JMP: cond_true = 1'b1;
      default:  cond_true = 1'b0;
    endcase
  end

  assign br_take    = (state == IDLE) && br_valid && cond_true;
  assign do_restore = (state == IDLE) && rti_restore && shadow_valid;

  // NOTE: every path assigns ccr_next from a default first, so no latch is inferred.
  always_comb begin
    ccr_next = flag_we ? {in_carry, in_neg, in_zero} : ccr;
    if (set_carry)      ccr_next[2] = 1'b1;
    else if (clr_carry) ccr_next[2] = 1'b0;
    if (br_take) begin
      case (br_cond)
        COND_JZ: ccr_next[0] = 1'b0;
        COND_JN: ccr_next[1] = 1'b0;
        COND_JC: ccr_next[2] = 1'b0;
        default: ;
      endcase
    end
    if (state == FLUSH) ccr_next = ccr;
    if (do_restore)     ccr_next = shadow;
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ccr          <= 3'b000;
      shadow       <= 3'b000;
      shadow_valid <= 1'b0;
      taken        <= 1'b0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      ccr <= ccr_next;

      if (state == IDLE && br_take) begin
        state       <= FLUSH;
        taken       <= 1'b1;
        flush       <= 1'b1;
        redirect_pc <= br_target;
      end else begin
        state <= IDLE;
        taken <= 1'b0;
        flush <= 1'b0;
      end

      // A save in the same cycle as a restore leaves a fresh, valid shadow.
      if (do_restore) shadow_valid <= 1'b0;
      if (int_save) begin
        shadow       <= ccr;
        shadow_valid <= 1'b1;
      end
    end
  end

endmodule
